// File: rtl/flag_cond_eval_pkg.sv
// Shared definitions for the ALU flag consumer: condition codes, flag bit
// positions within the {n,z,c,v} vector, and query FSM state encodings.
package flag_cond_eval_pkg;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

endpackage

// File: rtl/flag_cond_eval_cond_decode.sv
// Combinational condition-code evaluator: maps a 4-bit condition and the
// {n,z,c,v} flag vector to a taken bit plus an error for the reserved code.
module cond_decode
  import flag_cond_eval_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_nzcv,
  output logic       o_taken,
  output logic       o_err
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_nzcv[FLAG_N];
  assign w_z = i_nzcv[FLAG_Z];
  assign w_c = i_nzcv[FLAG_C];
  assign w_v = i_nzcv[FLAG_V];

  always_comb begin
    o_taken = 1'b0;
    o_err   = 1'b0;
    case (i_cond)
      COND_EQ: o_taken = w_z;
      COND_NE: o_taken = ~w_z;
      COND_CS: o_taken = w_c;
      COND_CC: o_taken = ~w_c;
      COND_MI: o_taken = w_n;
      COND_PL: o_taken = ~w_n;
      COND_VS: o_taken = w_v;
      COND_VC: o_taken = ~w_v;
      COND_HI: o_taken = w_c & ~w_z;
      COND_LS: o_taken = ~w_c | w_z;
      COND_GE: o_taken = (w_n == w_v);
      COND_LT: o_taken = (w_n != w_v);
      COND_GT: o_taken = ~w_z & (w_n == w_v);
      COND_LE: o_taken = w_z | (w_n != w_v);
      COND_AL: o_taken = 1'b1;
      COND_NV: o_err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_cond_eval.sv
// ALU flag consumer: architectural flag register, in-flight flag-write counter
// and a valid/ready condition query FSM that stalls until flags are settled.
module flag_cond_eval
  import flag_cond_eval_pkg::*;
#(
  parameter int PEND_W = 3,
  parameter int TO_W   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       flag_pend,
  input  logic       flag_we,
  input  logic       c_in,
  input  logic       n_in,
  input  logic       z_in,
  input  logic       v_in,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [3:0] cond,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_taken,
  output logic       res_err,
  output logic [3:0] flags_out,
  output logic       pend_ovf
);

  state_t            r_state;
  logic [3:0]        r_flags;
  logic [3:0]        r_cond;
  logic [PEND_W-1:0] r_pend;
  logic [TO_W-1:0]   r_to;
  logic              r_taken;
  logic              r_err;
  logic              r_ovf;

  logic [3:0]        w_flags_nx;
  logic [PEND_W-1:0] w_pend_nx;
  logic              w_pend_max;
  logic              w_pend_zero;
  logic              w_ovf_evt;
  logic              w_accept;
  logic [3:0]        w_eval_cond;
  logic              w_taken;
  logic              w_err;

  // Forward a same-cycle flag write so the evaluation sees the newest flags.
  assign w_flags_nx  = flag_we ? {n_in, z_in, c_in, v_in} : r_flags;
  assign w_pend_max  = &r_pend;
  assign w_pend_zero = (r_pend == '0);
  assign w_ovf_evt   = flag_pend & ~flag_we & w_pend_max;
  assign w_accept    = op_valid & (r_state == ST_IDLE);

  always_comb begin
    w_pend_nx = r_pend;
    if (flag_pend && !flag_we && !w_pend_max)
      w_pend_nx = r_pend + 1'b1;
    else if (flag_we && !flag_pend && !w_pend_zero)
      w_pend_nx = r_pend - 1'b1;
  end

  // In IDLE the query code arrives on the port; afterwards it is the latched one.
  assign w_eval_cond = (r_state == ST_IDLE) ? cond : r_cond;

  cond_decode u_cond_decode (
    .i_cond  (w_eval_cond),
    .i_nzcv  (w_flags_nx),
    .o_taken (w_taken),
    .o_err   (w_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_flags <= '0;
      r_cond  <= '0;
      r_pend  <= '0;
      r_to    <= '0;
      r_taken <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (flag_we)
        r_flags <= {n_in, z_in, c_in, v_in};
      r_pend <= w_pend_nx;
      if (w_ovf_evt)
        r_ovf <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_cond <= cond;
            if (w_pend_nx == '0) begin
              r_taken <= w_taken;
              r_err   <= w_err;
              r_state <= ST_RESULT;
            end else begin
              r_to    <= '0;
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (w_pend_nx == '0) begin
            r_taken <= w_taken;
            r_err   <= w_err;
            r_state <= ST_RESULT;
          end else if (&r_to) begin
            r_taken <= 1'b0;
            r_err   <= 1'b1;
            r_state <= ST_RESULT;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        ST_RESULT: begin
          if (res_ready)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign op_ready  = (r_state == ST_IDLE);
  assign res_valid = (r_state == ST_RESULT);
  assign res_taken = r_taken;
  assign res_err   = r_err;
  assign flags_out = r_flags;
  assign pend_ovf  = r_ovf;

endmodule

// File: tb/tb_flag_cond_eval.sv
// Directed and randomized checks of flag_cond_eval against a condition-table
// reference model kept in the bench.
module tb_flag_cond_eval;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flag_pend, flag_we;
  logic       c_in, n_in, z_in, v_in;
  logic       op_valid, op_ready;
  logic [3:0] cond;
  logic       res_valid, res_ready, res_taken, res_err;
  logic [3:0] flags_out;
  logic       pend_ovf;

  int total = 0;
  int bad   = 0;
  logic [3:0] m_flags;

  flag_cond_eval #(.PEND_W(3), .TO_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flag_pend (flag_pend),
    .flag_we   (flag_we),
    .c_in      (c_in),
    .n_in      (n_in),
    .z_in      (z_in),
    .v_in      (v_in),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .cond      (cond),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_taken (res_taken),
    .res_err   (res_err),
    .flags_out (flags_out),
    .pend_ovf  (pend_ovf)
  );

  always #5 clk = ~clk;

  // Conditions come in complementary pairs: odd codes invert the even base test.
  function automatic logic [1:0] ref_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, t;
    logic [2:0] pair;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'hF) return 2'b01;
    if (c == 4'hE) return 2'b10;
    pair = c[3:1];
    case (pair)
      3'd0:    t = z;
      3'd1:    t = cy;
      3'd2:    t = n;
      3'd3:    t = v;
      3'd4:    t = cy && !z;
      3'd5:    t = (n == v);
      default: t = !z && (n == v);
    endcase
    if (c[0]) t = !t;
    return {t, 1'b0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_we(input logic [3:0] f, input logic pend);
    {n_in, z_in, c_in, v_in} = f;
    flag_we = 1'b1;
    flag_pend = pend;
    tick();
    flag_we = 1'b0;
    flag_pend = 1'b0;
    m_flags = f;
  endtask

  task automatic do_pend(input int k);
    for (int i = 0; i < k; i++) begin
      flag_pend = 1'b1;
      tick();
    end
    flag_pend = 1'b0;
  endtask

  task automatic query(input logic [3:0] c);
    op_valid = 1'b1;
    cond = c;
    tick();
    op_valid = 1'b0;
  endtask

  task automatic collect(input string tag, input logic [1:0] exp);
    chk({tag, "_valid"}, res_valid, 1'b1);
    chk({tag, "_taken"}, res_taken, exp[1]);
    chk({tag, "_err"}, res_err, exp[0]);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_ready"}, op_ready, 1'b1);
  endtask

  initial begin
    int n;
    logic [3:0] f, c;
    logic [1:0] e;
    int np, gap;

    reset_n = 1'b0; flag_pend = 0; flag_we = 0; c_in = 0; n_in = 0; z_in = 0; v_in = 0;
    op_valid = 0; cond = 0; res_ready = 0; m_flags = 0;
    tick(); tick();
    chk("rst_ready", op_ready, 1'b1);
    chk("rst_valid", res_valid, 1'b0);
    chk("rst_taken", res_taken, 1'b0);
    chk("rst_err", res_err, 1'b0);
    chk("rst_flags", flags_out, 4'h0);
    chk("rst_ovf", pend_ovf, 1'b0);
    reset_n = 1'b1;
    tick();

    // 1: z=1 then EQ, one-cycle latency
    do_we(4'b0100, 1'b0);
    chk("t1_flags", flags_out, 4'b0100);
    query(4'h0);
    collect("t1", 2'b10);

    // 2: two pending writes, LT released by the second write
    do_pend(2);
    query(4'hB);
    chk("t2_wait_valid", res_valid, 1'b0);
    chk("t2_wait_ready", op_ready, 1'b0);
    do_we(4'b1000, 1'b0);
    chk("t2_still_wait", res_valid, 1'b0);
    do_we(4'b1000, 1'b0);
    collect("t2", ref_eval(4'hB, m_flags));

    // 3: simultaneous pend+we keeps count at 1
    do_pend(1);
    query(4'h0);
    do_we(4'b0000, 1'b1);
    chk("t3_still_wait", res_valid, 1'b0);
    do_we(4'b0100, 1'b0);
    collect("t3", 2'b10);

    // 4: reserved code, then timeout
    query(4'hF);
    collect("t4_nv", 2'b01);
    do_pend(1);
    query(4'hE);
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t4_timeout_cycles", n, 16);
    collect("t4_to", 2'b01);
    do_we(4'b0010, 1'b0);

    // 5: held result while flags keep changing
    query(4'hE);
    for (int i = 0; i < 5; i++) begin
      f = 4'($urandom_range(0, 15));
      do_we(f, 1'b0);
      chk("t5_valid", res_valid, 1'b1);
      chk("t5_taken", res_taken, 1'b1);
      chk("t5_err", res_err, 1'b0);
      chk("t5_ready", op_ready, 1'b0);
      chk("t5_flags", flags_out, m_flags);
    end
    collect("t5", 2'b10);

    // randomized queries against the reference model
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        f = 4'($urandom_range(0, 15));
        do_we(f, 1'b0);
      end
      np = $urandom_range(0, 3);
      do_pend(np);
      c = 4'($urandom_range(0, 15));
      query(c);
      for (int k = 0; k < np; k++) begin
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) begin
          tick();
          chk("rnd_gap_wait", res_valid, 1'b0);
        end
        f = 4'($urandom_range(0, 15));
        do_we(f, 1'b0);
        if (k < np - 1) chk("rnd_wait", res_valid, 1'b0);
      end
      e = ref_eval(c, m_flags);
      chk("rnd_flags", flags_out, m_flags);
      collect("rnd", e);
    end

    // 6: saturation at 7, sticky overflow, async reset mid-WAIT
    do_pend(7);
    chk("t6_ovf_pre", pend_ovf, 1'b0);
    do_pend(1);
    chk("t6_ovf", pend_ovf, 1'b1);
    query(4'h0);
    for (int i = 0; i < 6; i++) do_we(4'b0100, 1'b0);
    chk("t6_sat_wait", res_valid, 1'b0);
    do_we(4'b0100, 1'b0);
    collect("t6_sat", 2'b10);
    chk("t6_ovf_sticky", pend_ovf, 1'b1);
    do_pend(2);
    query(4'h1);
    tick();
    chk("t6_in_wait", op_ready, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_ready", op_ready, 1'b1);
    chk("t6_rst_valid", res_valid, 1'b0);
    chk("t6_rst_taken", res_taken, 1'b0);
    chk("t6_rst_err", res_err, 1'b0);
    chk("t6_rst_flags", flags_out, 4'h0);
    chk("t6_rst_ovf", pend_ovf, 1'b0);
    tick();
    reset_n = 1'b1;
    m_flags = 4'h0;
    tick();
    query(4'h1);
    collect("t6_post", ref_eval(4'h1, m_flags));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
